// File: rtl/serial_to_parallel.sv
// Serial-to-parallel receiver: assembles LSB-first words from a one-bit link and
// publishes each completed word on a holding register with a valid/acknowledge handshake.
module serial_to_parallel #(
  parameter int data_size = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 DATA,
  input  logic                 SHIFT_EN,
  input  logic                 CLEAR,
  input  logic                 READ_ACK,
  output logic [data_size-1:0] DATA_OUT,
  output logic                 VALID,
  output logic                 OVERRUN,
  output logic                 BUSY
);

  localparam int CW = $clog2(data_size);
  localparam logic [CW-1:0] LAST = CW'(data_size - 1);

  logic [data_size-1:0] sr;
  logic [CW-1:0]        cnt;
  logic                 complete;

  // Handshake: VALID rises on the edge that samples the last bit of a word and
  // falls on the edge where READ_ACK=1 is sampled; a completion in the same cycle
  // as READ_ACK replaces the acknowledged word and keeps VALID high.
  assign complete = SHIFT_EN && !CLEAR && (cnt == LAST);
  assign BUSY     = (cnt != '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sr       <= '0;
      cnt      <= '0;
      DATA_OUT <= '0;
      VALID    <= 1'b0;
      OVERRUN  <= 1'b0;
    end else begin
      if (CLEAR) begin
        // Abort drops the partial word and any bit offered in the same cycle.
        sr      <= '0;
        cnt     <= '0;
        OVERRUN <= 1'b0;
      end else if (SHIFT_EN) begin
        if (cnt == LAST) begin
          DATA_OUT <= {DATA, sr[data_size-1:1]};
          sr       <= '0;
          cnt      <= '0;
          if (VALID && !READ_ACK) begin
            OVERRUN <= 1'b1;
          end
        end else begin
          sr  <= {DATA, sr[data_size-1:1]};
          cnt <= cnt + CW'(1);
        end
      end

      if (complete) begin
        VALID <= 1'b1;
      end else if (READ_ACK) begin
        VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_to_parallel.sv
// Bench for serial_to_parallel: 8-bit instance against a queue-based model with
// directed and random traffic, plus a 64-bit back-to-back loopback instance.
module tb_serial_to_parallel;

  localparam int N = 8;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       d8 = 1'b0, s8 = 1'b0, c8 = 1'b0, a8 = 1'b0;
  logic [7:0] q8;
  logic       v8, o8, b8;

  logic        d64 = 1'b0, s64 = 1'b0, c64 = 1'b0, a64 = 1'b0;
  logic [63:0] q64;
  logic        v64, o64, b64;

  serial_to_parallel #(.data_size(8)) dut8 (
    .CLK(clk), .RST(rst), .DATA(d8), .SHIFT_EN(s8), .CLEAR(c8), .READ_ACK(a8),
    .DATA_OUT(q8), .VALID(v8), .OVERRUN(o8), .BUSY(b8)
  );

  serial_to_parallel #(.data_size(64)) dut64 (
    .CLK(clk), .RST(rst), .DATA(d64), .SHIFT_EN(s64), .CLEAR(c64), .READ_ACK(a64),
    .DATA_OUT(q64), .VALID(v64), .OVERRUN(o64), .BUSY(b64)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: received bits held in a queue, word formed by weighting bit i by 2**i
  bit         m_bits[$];
  logic [7:0] m_dout;
  logic       m_valid;
  logic       m_ovr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic model_step(input logic d, input logic s, input logic c, input logic a);
    logic       done;
    logic [7:0] w;
    done = 1'b0;
    if (c) begin
      m_bits.delete();
      m_ovr = 1'b0;
    end else if (s) begin
      m_bits.push_back(d);
      if (m_bits.size() == N) begin
        w = '0;
        foreach (m_bits[i]) w[i] = m_bits[i];
        if (m_valid && !a) m_ovr = 1'b1;
        m_dout = w;
        m_bits.delete();
        done = 1'b1;
      end
    end
    if (done) m_valid = 1'b1;
    else if (a) m_valid = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_dout"}, q8, m_dout);
    chk({tag, "_valid"}, v8, m_valid);
    chk({tag, "_ovr"}, o8, m_ovr);
    chk({tag, "_busy"}, b8, (m_bits.size() != 0));
  endtask

  // Driver: inputs applied just after an edge, outputs checked 1ns after the next edge
  task automatic cyc8(input logic d, input logic s, input logic c, input logic a, input string tag);
    d8 = d; s8 = s; c8 = c; a8 = a;
    @(posedge clk);
    model_step(d, s, c, a);
    #1;
    check_model(tag);
  endtask

  task automatic send8(input logic [7:0] w, input logic ack_last, input string tag);
    for (int i = 0; i < N; i++) begin
      cyc8(w[i], 1'b1, 1'b0, (i == N - 1) ? ack_last : 1'b0, tag);
    end
    d8 = 1'b0; s8 = 1'b0; c8 = 1'b0; a8 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] words [0:1];
    logic [63:0] got [$];
    int          rise [$];
    logic        pv;
    logic        ackp;

    model_reset();
    #12;
    chk("reset_dout8", q8, 8'h00);
    chk("reset_valid8", v8, 1'b0);
    chk("reset_ovr8", o8, 1'b0);
    chk("reset_busy8", b8, 1'b0);
    chk("reset_dout64", q64, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic receive: bits 1,0,1,1,0,0,1,0 -> 8'h4D
    send8(8'h4D, 1'b0, "basic");
    chk("basic_word", q8, 8'h4D);
    chk("basic_valid", v8, 1'b1);
    chk("basic_busy", b8, 1'b0);
    cyc8(1'b0, 1'b0, 1'b0, 1'b1, "basic_ack");
    chk("basic_ack_valid", v8, 1'b0);
    chk("basic_hold_dout", q8, 8'h4D);

    // Overrun: newest word wins, CLEAR drops the flag but not the word
    send8(8'hAA, 1'b0, "ovr_a");
    send8(8'h55, 1'b0, "ovr_b");
    chk("ovr_word", q8, 8'h55);
    chk("ovr_flag", o8, 1'b1);
    cyc8(1'b0, 1'b0, 1'b1, 1'b0, "ovr_clear");
    chk("ovr_cleared", o8, 1'b0);
    chk("ovr_keep_word", q8, 8'h55);
    chk("ovr_keep_valid", v8, 1'b1);
    cyc8(1'b0, 1'b0, 1'b0, 1'b1, "ovr_ack");

    // Acknowledge on the completing edge
    send8(8'hC3, 1'b0, "simul_a");
    send8(8'h3C, 1'b1, "simul_b");
    chk("simul_word", q8, 8'h3C);
    chk("simul_valid", v8, 1'b1);
    chk("simul_ovr", o8, 1'b0);
    cyc8(1'b0, 1'b0, 1'b0, 1'b1, "simul_ack");

    // CLEAR mid-word with a competing shift
    cyc8(1'b1, 1'b1, 1'b0, 1'b0, "clr_b0");
    cyc8(1'b1, 1'b1, 1'b0, 1'b0, "clr_b1");
    cyc8(1'b0, 1'b1, 1'b0, 1'b0, "clr_b2");
    chk("clr_busy_before", b8, 1'b1);
    cyc8(1'b1, 1'b1, 1'b1, 1'b0, "clr_abort");
    chk("clr_busy_after", b8, 1'b0);
    send8(8'h81, 1'b0, "clr_word");
    chk("clr_word_val", q8, 8'h81);
    cyc8(1'b0, 1'b0, 1'b0, 1'b1, "clr_ack");

    // Asynchronous reset in the middle of a word
    send8(8'h77, 1'b0, "pre_rst");
    for (int i = 0; i < 4; i++) cyc8(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, "pre_rst_bits");
    #2;
    rst = 1'b1;
    s8 = 1'b0; d8 = 1'b0;
    model_reset();
    #1;
    chk("arst_dout", q8, 8'h00);
    chk("arst_valid", v8, 1'b0);
    chk("arst_busy", b8, 1'b0);
    chk("arst_ovr", o8, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send8(8'h5A, 1'b0, "post_rst");
    chk("post_rst_word", q8, 8'h5A);
    cyc8(1'b0, 1'b0, 1'b0, 1'b1, "post_rst_ack");

    // Random traffic against the model
    for (int k = 0; k < 300; k++) begin
      cyc8(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) == 0), "rand");
    end
    d8 = 1'b0; s8 = 1'b0; c8 = 1'b0; a8 = 1'b0;

    // 64-bit loopback: two words back-to-back, one bit per cycle
    words[0] = 64'h0123_4567_89AB_CDEF;
    words[1] = 64'hFFFF_0000_A5A5_5A5A;
    pv   = v64;
    ackp = 1'b0;
    for (int k = 0; k < 128; k++) begin
      d64  = words[k / 64][k % 64];
      s64  = 1'b1;
      a64  = ackp;
      ackp = 1'b0;
      @(posedge clk);
      #1;
      if (v64 && !pv) begin
        rise.push_back(k + 1);
        got.push_back(q64);
        ackp = 1'b1;
      end
      pv = v64;
    end
    s64 = 1'b0; a64 = 1'b0;
    chk("lb_count", rise.size(), 2);
    if (rise.size() == 2) begin
      chk("lb_rise0", rise[0], 64);
      chk("lb_rise1", rise[1], 128);
      chk("lb_word0", got[0], words[0]);
      chk("lb_word1", got[1], words[1]);
    end
    chk("lb_ovr", o64, 1'b0);
    chk("lb_busy", b64, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_to_parallel.md
# serial_to_parallel

Serial-to-parallel shift register that reassembles words sent LSB-first by the parallel-to-serial transmitter, for example a row of cell states streamed between the Conway grid and its neighbours. It counts received bits and publishes each complete word on a holding register with a valid/acknowledge handshake. It flags a word completed before the previous one was consumed. It sits at the receiving end of every serial cell link in the grid.

## Interface
- data_size, default 64, word width in bits; must be ≥ 2
- CLK  input  1  clock; all state changes on its rising edge
- RST  input  1  asynchronous, active-high reset
- DATA  input  1  serial data in, LSB of the word first
- SHIFT_EN  input  1  sample DATA this cycle
- CLEAR  input  1  synchronous abort: discard the partial word and clear OVERRUN
- READ_ACK  input  1  consumer takes DATA_OUT this cycle
- DATA_OUT  output  data_size  last completed word (registered)
- VALID  output  1  DATA_OUT holds an unconsumed word
- OVERRUN  output  1  sticky flag: a word completed while VALID was 1 and not acknowledged
- BUSY  output  1  partial word in progress (bit count ≠ 0)

## Operation
- Internal state:
  - shift register SR[data_size-1:0]
  - bit counter CNT, width $clog2(data_size), range 0..data_size-1
- Reset (RST=1, asynchronous): SR=0, CNT=0, DATA_OUT=0, VALID=0, OVERRUN=0, BUSY=0.
- Per-cycle priority: CLEAR, then SHIFT_EN. READ_ACK is evaluated independently.
- CLEAR=1: SR=0 and CNT=0; OVERRUN cleared; DATA_OUT and VALID unaffected; any SHIFT_EN in the same cycle is ignored (the bit is dropped). READ_ACK is still honoured.
- SHIFT_EN=1 with CNT < data_size-1: SR <= {DATA, SR[data_size-1:1]}; CNT <= CNT+1.
- SHIFT_EN=1 with CNT = data_size-1 (word completes):
  - DATA_OUT <= {DATA, SR[data_size-1:1]}; the first bit received lands in bit 0.
  - SR <= 0; CNT <= 0; VALID <= 1.
  - If VALID=1 and READ_ACK=0 this cycle: OVERRUN <= 1 and the old word is overwritten (newest word wins).
- READ_ACK=1 with VALID=1 and no completion this cycle: VALID <= 0.
- READ_ACK=1 in the same cycle as a completion: the old word is consumed and the new one loaded; VALID stays 1; no overrun.
- READ_ACK=1 with VALID=0: ignored.
- SHIFT_EN=0: SR and CNT hold; there is no timeout.
- BUSY = (CNT ≠ 0), combinational from the registered count.

## Timing
- Transmitter pairing: the transmitter's DATA output is registered and presents a bit one cycle after its SHIFT_EN. The integration delays that enable by one cycle to drive this block's SHIFT_EN. No gap is required between words.
- Latency: DATA_OUT and VALID update on the edge that samples bit data_size-1, so they are visible in the following cycle.
- Throughput: one bit per cycle; back-to-back words need data_size cycles each, with no dead cycle.
- VALID deasserts on the edge where READ_ACK=1 is sampled; DATA_OUT holds its last value after consumption.
- Reset mid-word: all state clears immediately, independent of CLK; the partial word is lost. After release, the next sampled bit is treated as bit 0.

## Test plan
- Reset: assert RST mid-stream, asynchronously → all outputs 0 before the next CLK edge; the first word after release is assembled from bit 0.
- Basic receive (data_size=8): shift bits 1,0,1,1,0,0,1,0 → DATA_OUT=8'h4D, VALID=1 the cycle after the 8th bit, BUSY=0 at that point; READ_ACK=1 → VALID=0 the next cycle.
- Loopback: 64-bit transmitter → this block with a one-cycle-delayed enable, words 64'h0123_4567_89AB_CDEF then 64'hFFFF_0000_A5A5_5A5A sent back-to-back → both received intact, VALID pulses 64 cycles apart.
- Overrun (data_size=8): receive 8'hAA without ack, then 8'h55 → DATA_OUT=8'h55, VALID=1, OVERRUN=1; CLEAR=1 → OVERRUN=0 and DATA_OUT still 8'h55.
- Simultaneous ack and completion: READ_ACK=1 on the edge completing 8'h3C while 8'hC3 is pending → DATA_OUT=8'h3C, VALID=1, OVERRUN=0.
- CLEAR mid-word: 3 bits shifted, then CLEAR with SHIFT_EN=1 → CNT=0, BUSY=0; the next 8 bits form 8'h81 exactly.
